// File: rtl/lbp.sv
// -----------------------------------------------------------------------------
// lbp : Local Binary Pattern engine
//
// Walks the interior of a W x W 8-bit grayscale image held in an external
// memory. For each interior pixel it computes an 8-bit LBP code and writes it
// to an external result memory at the same address as the centre pixel.
// A 3x3 window of byte registers slides along each row. The first pixel of a
// row loads all 9 pixels. Every later pixel shifts the window left and loads
// only the new right-hand column.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   gray_ready  in   gray memory available; requests issue only while high
//   gray_req    out  read request for gray_addr (registered)
//   gray_addr   out  pixel address, row*W + col (registered)
//   gray_data   in   pixel for the request issued in the previous cycle
//   lbp_valid   out  one-cycle strobe, lbp_addr/lbp_data valid
//   lbp_addr    out  result address (centre pixel address)
//   lbp_data    out  LBP code
//   finish      out  whole image written; held until reset
// -----------------------------------------------------------------------------
module lbp #(
   parameter int W  = 128,
   parameter int AW = 14,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          gray_ready,
   output logic          gray_req,
   output logic [AW-1:0] gray_addr,
   input  logic [DW-1:0] gray_data,
   output logic          lbp_valid,
   output logic [AW-1:0] lbp_addr,
   output logic [DW-1:0] lbp_data,
   output logic          finish
);

   localparam int CW = $clog2(W);
   localparam logic [AW-1:0] WA = AW'(W);
   localparam logic [CW-1:0] LAST = CW'(W - 2);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WRITE,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] row;
   logic [CW-1:0] col;
   logic          full_fetch;
   logic [3:0]    req_cnt;
   logic [3:0]    cap_cnt;
   logic [DW-1:0] win [3][3];

   logic [3:0]    n_reads;
   logic [3:0]    req_slot;
   logic [3:0]    cap_slot;
   logic [CW-1:0] req_row;
   logic [CW-1:0] req_col;
   logic [AW-1:0] req_addr;
   logic [AW-1:0] pix_addr;
   logic [DW-1:0] centre;
   logic [DW-1:0] code;

   // Maps the n-th read of a fetch to a window slot {row_ofs, col_ofs}.
   // A full fetch walks column by column (top to bottom). A partial fetch
   // fills only the right-hand column.
   function automatic logic [3:0] slot_of(input logic [3:0] idx, input logic full);
      logic [3:0] s;
      if (!full) begin
         s = {idx[1:0], 2'd2};
      end else begin
         case (idx)
            4'd0:    s = {2'd0, 2'd0};
            4'd1:    s = {2'd1, 2'd0};
            4'd2:    s = {2'd2, 2'd0};
            4'd3:    s = {2'd0, 2'd1};
            4'd4:    s = {2'd1, 2'd1};
            4'd5:    s = {2'd2, 2'd1};
            4'd6:    s = {2'd0, 2'd2};
            4'd7:    s = {2'd1, 2'd2};
            default: s = {2'd2, 2'd2};
         endcase
      end
      return s;
   endfunction

   // Request address, capture slot and the LBP code of the current window.
   // The window offsets are relative to (row-1, col-1). Because row and col
   // stay inside 1..W-2, every address stays inside the image.
   always_comb begin
      n_reads  = full_fetch ? 4'd9 : 4'd3;
      req_slot = slot_of(req_cnt, full_fetch);
      cap_slot = slot_of(cap_cnt, full_fetch);
      req_row  = row + CW'(req_slot[3:2]) - CW'(1);
      req_col  = col + CW'(req_slot[1:0]) - CW'(1);
      req_addr = AW'(req_row) * WA + AW'(req_col);
      pix_addr = AW'(row) * WA + AW'(col);
      centre   = win[1][1];
      code     = {win[2][2] >= centre, win[2][1] >= centre, win[2][0] >= centre,
                  win[1][2] >= centre, win[1][0] >= centre,
                  win[0][2] >= centre, win[0][1] >= centre, win[0][0] >= centre};
   end

   // Control FSM with registered outputs.
   // FETCH issues one request per cycle while gray_ready is high. It captures
   // each datum one cycle after its request, because a registered gray_req
   // means data is on gray_data now. WRITE emits the code, then shifts the
   // window for the next column.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         row        <= CW'(1);
         col        <= CW'(1);
         full_fetch <= 1'b1;
         req_cnt    <= '0;
         cap_cnt    <= '0;
         gray_req   <= 1'b0;
         gray_addr  <= '0;
         lbp_valid  <= 1'b0;
         lbp_addr   <= '0;
         lbp_data   <= '0;
         finish     <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               win[i][j] <= '0;
            end
         end
      end else begin
         case (state)
            IDLE: begin
               gray_req  <= 1'b0;
               lbp_valid <= 1'b0;
               req_cnt   <= '0;
               cap_cnt   <= '0;
               if (gray_ready) begin
                  state <= FETCH;
               end
            end

            FETCH: begin
               lbp_valid <= 1'b0;
               if (gray_ready && (req_cnt < n_reads)) begin
                  gray_req  <= 1'b1;
                  gray_addr <= req_addr;
                  req_cnt   <= req_cnt + 4'd1;
               end else begin
                  gray_req <= 1'b0;
               end
               if (gray_req) begin
                  win[cap_slot[3:2]][cap_slot[1:0]] <= gray_data;
                  cap_cnt <= cap_cnt + 4'd1;
                  if (cap_cnt == n_reads - 4'd1) begin
                     state <= WRITE;
                  end
               end
            end

            WRITE: begin
               gray_req  <= 1'b0;
               lbp_valid <= 1'b1;
               lbp_addr  <= pix_addr;
               lbp_data  <= code;
               req_cnt   <= '0;
               cap_cnt   <= '0;
               for (int i = 0; i < 3; i++) begin
                  win[i][0] <= win[i][1];
                  win[i][1] <= win[i][2];
               end
               if ((row == LAST) && (col == LAST)) begin
                  state <= DONE;
               end else begin
                  state <= FETCH;
                  if (col == LAST) begin
                     col        <= CW'(1);
                     row        <= row + CW'(1);
                     full_fetch <= 1'b1;
                  end else begin
                     col        <= col + CW'(1);
                     full_fetch <= 1'b0;
                  end
               end
            end

            DONE: begin
               gray_req  <= 1'b0;
               lbp_valid <= 1'b0;
               finish    <= 1'b1;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lbp.sv
// -----------------------------------------------------------------------------
// tb_lbp : self-checking bench for lbp on a 32x32 image.
// A golden LBP is queued for every interior pixel in raster order. Each
// lbp_valid strobe pops the queue and is compared. The final result memory is
// also compared against the golden image, with zeros on the border.
// -----------------------------------------------------------------------------
module tb_lbp;

   localparam int W    = 32;
   localparam int AW   = 10;
   localparam int DW   = 8;
   localparam int NPIX = W * W;
   localparam int NINT = (W - 2) * (W - 2);

   logic          clk;
   logic          reset;
   logic          gray_ready;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic [DW-1:0] gray_data;
   logic          lbp_valid;
   logic [AW-1:0] lbp_addr;
   logic [DW-1:0] lbp_data;
   logic          finish;

   logic [DW-1:0]    gray_mem [NPIX];
   logic [DW-1:0]    res_mem  [NPIX];
   logic [AW+DW-1:0] sbq [$];

   int compared   = 0;
   int mismatched = 0;
   int pulses     = 0;

   lbp #(.W(W), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .gray_ready (gray_ready),
      .gray_req   (gray_req),
      .gray_addr  (gray_addr),
      .gray_data  (gray_data),
      .lbp_valid  (lbp_valid),
      .lbp_addr   (lbp_addr),
      .lbp_data   (lbp_data),
      .finish     (finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] goldenLbp(input int r, input int c);
      int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
      int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
      logic [DW-1:0] g;
      logic [DW-1:0] code;
      g    = gray_mem[r * W + c];
      code = '0;
      for (int k = 0; k < 8; k++) begin
         if (gray_mem[(r + dr[k]) * W + c + dc[k]] >= g) code[k] = 1'b1;
      end
      return code;
   endfunction

   function automatic logic [DW-1:0] expectedAt(input int a);
      int r;
      int c;
      r = a / W;
      c = a % W;
      if (r >= 1 && r <= W - 2 && c >= 1 && c <= W - 2) return goldenLbp(r, c);
      return '0;
   endfunction

   // Gray memory model and result memory. Data for a request is driven on
   // the falling edge, ready for the next rising edge. Each write strobe is
   // committed to the result memory and checked against the scoreboard.
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      gray_data = (gray_req === 1'b1) ? gray_mem[gray_addr] : 'z;
      if (reset === 1'b1 && lbp_valid === 1'b1) begin
         res_mem[lbp_addr] = lbp_data;
         pulses++;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkEq("sb_addr", 32'(lbp_addr), 32'(e[AW+DW-1:DW]));
            checkEq("sb_data", 32'(lbp_data), 32'(e[DW-1:0]));
         end else begin
            checkEq("sb_extra_write", 32'(lbp_addr), 32'hFFFF_FFFF);
         end
      end
   end

   task automatic fillImage(input int pattern);
      for (int a = 0; a < NPIX; a++) begin
         case (pattern)
            0:       gray_mem[a] = 8'h40;
            1:       gray_mem[a] = 8'(a % W);
            2:       gray_mem[a] = (a == 5 * W + 5) ? 8'd50 : 8'd100;
            default: gray_mem[a] = 8'($urandom_range(0, 255));
         endcase
      end
   endtask

   task automatic applyStimulus();
      sbq.delete();
      pulses = 0;
      for (int a = 0; a < NPIX; a++) res_mem[a] = '0;
      for (int r = 1; r <= W - 2; r++) begin
         for (int c = 1; c <= W - 2; c++) begin
            sbq.push_back({AW'(r * W + c), goldenLbp(r, c)});
         end
      end
   endtask

   task automatic resetDut();
      @(negedge clk);
      gray_ready = 1'b0;
      reset      = 1'b0;
      #1;
      checkEq("rst_gray_req",  32'(gray_req),  32'd0);
      checkEq("rst_gray_addr", 32'(gray_addr), 32'd0);
      checkEq("rst_lbp_valid", 32'(lbp_valid), 32'd0);
      checkEq("rst_lbp_addr",  32'(lbp_addr),  32'd0);
      checkEq("rst_lbp_data",  32'(lbp_data),  32'd0);
      checkEq("rst_finish",    32'(finish),    32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic waitFinish(input string tag);
      int n = 0;
      while (finish !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      checkEq({tag, "_finish_in_budget"}, 32'(finish), 32'd1);
   endtask

   task automatic checkOutput(input string tag);
      int bad = 0;
      repeat (3) @(negedge clk);
      checkEq({tag, "_finish_held"},   32'(finish),     32'd1);
      checkEq({tag, "_idle_req"},      32'(gray_req),   32'd0);
      checkEq({tag, "_idle_valid"},    32'(lbp_valid),  32'd0);
      checkEq({tag, "_sb_drained"},    32'(sbq.size()), 32'd0);
      checkEq({tag, "_pulse_count"},   32'(pulses),     32'(NINT));
      for (int a = 0; a < NPIX; a++) begin
         if (res_mem[a] !== expectedAt(a)) bad++;
      end
      checkEq({tag, "_mem_mismatches"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int n;
      logic seen;
      reset      = 1'b0;
      gray_ready = 1'b0;
      gray_data  = 'z;

      // Flat image: every interior code is 0xFF, border untouched
      fillImage(0);
      resetDut();
      applyStimulus();
      gray_ready = 1'b1;
      waitFinish("t1");
      checkOutput("t1");
      checkEq("t1_first_interior", 32'(res_mem[W + 1]), 32'hFF);
      checkEq("t1_last_interior",  32'(res_mem[(W - 2) * W + W - 2]), 32'hFF);
      checkEq("t1_corner0",        32'(res_mem[0]), 32'h00);
      checkEq("t1_corner_last",    32'(res_mem[NPIX - 1]), 32'h00);
      checkEq("t1_right_border",   32'(res_mem[3 * W + W - 1]), 32'h00);

      // Horizontal ramp P(r,c)=c gives 0xD6
      fillImage(1);
      resetDut();
      applyStimulus();
      gray_ready = 1'b1;
      waitFinish("t2");
      checkOutput("t2");
      checkEq("t2_ramp_code",  32'(res_mem[3 * W + 7]), 32'hD6);
      checkEq("t2_left_border", 32'(res_mem[3 * W]), 32'h00);

      // Single dark pixel at (5,5) among 100s
      fillImage(2);
      resetDut();
      applyStimulus();
      gray_ready = 1'b1;
      waitFinish("t3");
      checkOutput("t3");
      checkEq("t3_p55", 32'(res_mem[5 * W + 5]), 32'hFF);
      checkEq("t3_p44", 32'(res_mem[4 * W + 4]), 32'h7F);
      checkEq("t3_p45", 32'(res_mem[4 * W + 5]), 32'hBF);
      checkEq("t3_p66", 32'(res_mem[6 * W + 6]), 32'hFE);
      checkEq("t3_p54", 32'(res_mem[5 * W + 4]), 32'hEF);
      checkEq("t3_p77", 32'(res_mem[7 * W + 7]), 32'hFF);

      // gray_ready held low for 20 cycles after reset
      fillImage(3);
      resetDut();
      applyStimulus();
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (gray_req !== 1'b0) seen = 1'b1;
      end
      checkEq("t4_no_req_while_not_ready", 32'(seen), 32'd0);
      checkEq("t4_no_write_while_not_ready", 32'(pulses), 32'd0);
      gray_ready = 1'b1;
      waitFinish("t4");
      checkOutput("t4");

      // Reset midway through the image, then a full rerun
      fillImage(3);
      resetDut();
      applyStimulus();
      gray_ready = 1'b1;
      n = 0;
      while (pulses < (W / 2) * (W - 2) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      checkEq("t5_reached_midpoint", 32'(pulses >= (W / 2) * (W - 2)), 32'd1);
      resetDut();
      applyStimulus();
      gray_ready = 1'b1;
      waitFinish("t5");
      checkOutput("t5");

      // Random image with gray_ready dropped for a while mid-run
      fillImage(3);
      resetDut();
      applyStimulus();
      gray_ready = 1'b1;
      repeat (700) @(negedge clk);
      gray_ready = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (gray_req !== 1'b0) seen = 1'b1;
      end
      checkEq("t6_no_req_after_ready_drop", 32'(seen), 32'd0);
      gray_ready = 1'b1;
      waitFinish("t6");
      checkOutput("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
